// File: rtl/sram_ctrl.sv
// Bridges one 32-bit memory-bus request onto an external async 16-bit SRAM, low half first.
// Latency: read/full write 2*WAIT_CYCLES+3, single-half write WAIT_CYCLES+3, range error 1 cycle.
// Backpressure: requests are taken only in IDLE; a mem_valid strobe while busy is dropped.

package sram_ctrl_pkg;
   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic        mem_error;
      logic [31:0] mem_rdata;
   } mem_out_type;

   localparam mem_out_type init_mem_out = '{mem_ready: 1'b0, mem_error: 1'b0, mem_rdata: 32'h0};
endpackage

module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned ADDR_BITS   = 19
) (
   input  logic                 clock,
   input  logic                 reset,
   input  mem_in_type           ram_in,
   output mem_out_type          ram_out,
   output logic [ADDR_BITS-1:0] sram_addr,
   output logic [15:0]          sram_dq_o,
   input  logic [15:0]          sram_dq_i,
   output logic                 sram_dq_oe,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output logic                 sram_lb_n,
   output logic                 sram_ub_n
);

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic lb_n;
      logic ub_n;
      logic dq_oe;
   } strobe_t;

   localparam strobe_t    STRB_IDLE  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                         lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};
   // Last cycle of a phase, and the last cycle with we_n low.
   localparam logic [3:0] CNT_LAST   = 4'(WAIT_CYCLES);
   localparam logic [3:0] CNT_WE_END = 4'(WAIT_CYCLES - 1);

   state_t               state_q;
   logic [3:0]           cnt_q;
   logic                 wr_q;
   logic [3:0]           wstrb_q;
   logic [31:0]          wdata_q;
   logic [ADDR_BITS-2:0] word_q;
   logic [15:0]          rd_lo_q;
   strobe_t              strb_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [15:0]          dq_q;
   mem_out_type          out_q;

   logic req_wr;
   logic req_err;
   logic skip_lo;
   logic skip_hi;
   logic unused_bits;

   assign req_wr      = |ram_in.mem_wstrb;
   assign req_err     = |ram_in.mem_addr[31:ADDR_BITS+1];
   // A write phase with no enabled lane spends one idle cycle instead of strobing.
   assign skip_lo     = wr_q && (wstrb_q[1:0] == 2'b00);
   assign skip_hi     = wr_q && (wstrb_q[3:2] == 2'b00);
   // Instruction fetches are plain reads; the byte offset within the word is irrelevant.
   assign unused_bits = ram_in.mem_instr ^ (^ram_in.mem_addr[1:0]);

   // Strobes for the first cycle of an active phase; we_n is released by the counter.
   function automatic strobe_t phase_strb(input logic wr, input logic [1:0] lanes);
      strobe_t s;
      s.ce_n  = 1'b0;
      s.oe_n  = wr;
      s.we_n  = ~wr;
      s.lb_n  = wr ? ~lanes[0] : 1'b0;
      s.ub_n  = wr ? ~lanes[1] : 1'b0;
      s.dq_oe = wr;
      return s;
   endfunction

   // Access sequencer: IDLE -> LO -> HI -> RESP, all pad and bus outputs registered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         wstrb_q <= 4'd0;
         wdata_q <= 32'h0;
         word_q  <= '0;
         rd_lo_q <= 16'h0;
         strb_q  <= STRB_IDLE;
         addr_q  <= '0;
         dq_q    <= 16'h0;
         out_q   <= init_mem_out;
      end else begin
         case (state_q)
            IDLE: begin
               out_q <= init_mem_out;
               if (ram_in.mem_valid) begin
                  if (req_err) begin
                     out_q.mem_ready <= 1'b1;
                     out_q.mem_error <= 1'b1;
                  end else begin
                     state_q <= LO;
                     cnt_q   <= 4'd0;
                     wr_q    <= req_wr;
                     wstrb_q <= ram_in.mem_wstrb;
                     wdata_q <= ram_in.mem_wdata;
                     word_q  <= ram_in.mem_addr[ADDR_BITS:2];
                     addr_q  <= {ram_in.mem_addr[ADDR_BITS:2], 1'b0};
                     dq_q    <= ram_in.mem_wdata[15:0];
                     strb_q  <= (req_wr && (ram_in.mem_wstrb[1:0] == 2'b00))
                                ? STRB_IDLE : phase_strb(req_wr, ram_in.mem_wstrb[1:0]);
                  end
               end
            end
            LO: begin
               if (skip_lo || (cnt_q == CNT_LAST)) begin
                  if (!wr_q) rd_lo_q <= sram_dq_i;
                  state_q <= HI;
                  cnt_q   <= 4'd0;
                  addr_q  <= {word_q, 1'b1};
                  dq_q    <= wdata_q[31:16];
                  strb_q  <= skip_hi ? STRB_IDLE : phase_strb(wr_q, wstrb_q[3:2]);
               end else begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == CNT_WE_END) strb_q.we_n <= 1'b1;
               end
            end
            HI: begin
               if (skip_hi || (cnt_q == CNT_LAST)) begin
                  state_q         <= RESP;
                  strb_q          <= STRB_IDLE;
                  out_q.mem_ready <= 1'b1;
                  out_q.mem_error <= 1'b0;
                  out_q.mem_rdata <= wr_q ? 32'h0 : {sram_dq_i, rd_lo_q};
               end else begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == CNT_WE_END) strb_q.we_n <= 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               out_q   <= init_mem_out;
            end
            default: begin
               state_q <= IDLE;
               strb_q  <= STRB_IDLE;
               out_q   <= init_mem_out;
            end
         endcase
      end
   end

   assign ram_out    = out_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_q;
   assign sram_dq_oe = strb_q.dq_oe;
   assign sram_ce_n  = strb_q.ce_n;
   assign sram_oe_n  = strb_q.oe_n;
   assign sram_we_n  = strb_q.we_n;
   assign sram_lb_n  = strb_q.lb_n;
   assign sram_ub_n  = strb_q.ub_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 16-bit SRAM on the main instance.
// Extra W=1 and W=15 instances read a fixed pattern to check latency scaling.
// Each scenario task drives a request, watches the pads cycle by cycle and compares inline.

module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   mem_in_type  m_in;
   mem_out_type m_out;
   logic [18:0] sram_addr;
   logic [15:0] sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

   mem_in_type  x_in;
   mem_out_type x1_out, x15_out;
   logic [18:0] x1_addr, x15_addr;
   logic [15:0] x1_dq_o, x15_dq_o, x1_dq_i, x15_dq_i;
   logic        x1_oe, x1_ce_n, x1_oe_n, x1_we_n, x1_lb_n, x1_ub_n;
   logic        x15_oe, x15_ce_n, x15_oe_n, x15_we_n, x15_lb_n, x15_ub_n;

   logic [15:0] sram_mem [0:255];

   int n_vec = 0;
   int n_err = 0;

   sram_ctrl #(.WAIT_CYCLES(2), .ADDR_BITS(19)) u_dut (
      .clock(clk), .reset(rst_n), .ram_in(m_in), .ram_out(m_out),
      .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n));

   sram_ctrl #(.WAIT_CYCLES(1), .ADDR_BITS(19)) u_w1 (
      .clock(clk), .reset(rst_n), .ram_in(x_in), .ram_out(x1_out),
      .sram_addr(x1_addr), .sram_dq_o(x1_dq_o), .sram_dq_i(x1_dq_i), .sram_dq_oe(x1_oe),
      .sram_ce_n(x1_ce_n), .sram_oe_n(x1_oe_n), .sram_we_n(x1_we_n),
      .sram_lb_n(x1_lb_n), .sram_ub_n(x1_ub_n));

   sram_ctrl #(.WAIT_CYCLES(15), .ADDR_BITS(19)) u_w15 (
      .clock(clk), .reset(rst_n), .ram_in(x_in), .ram_out(x15_out),
      .sram_addr(x15_addr), .sram_dq_o(x15_dq_o), .sram_dq_i(x15_dq_i), .sram_dq_oe(x15_oe),
      .sram_ce_n(x15_ce_n), .sram_oe_n(x15_oe_n), .sram_we_n(x15_we_n),
      .sram_lb_n(x15_lb_n), .sram_ub_n(x15_ub_n));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM model: lane writes while ce_n/we_n are low, data visible while ce_n/oe_n are low.
   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         if (!sram_lb_n) sram_mem[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
         if (!sram_ub_n) sram_mem[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
      end
   end
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 16'hFFFF;
   assign x1_dq_i   = x1_addr[0]  ? 16'h1234 : 16'h5678;
   assign x15_dq_i  = x15_addr[0] ? 16'h1234 : 16'h5678;

   // Issues one request to the main instance and records what the pads and bus did.
   task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            input int again_at, input int maxc,
                            output int rdy_at, output int n_rdy, output logic [31:0] rdata,
                            output logic err, output int we_lo, output int oe_lo, output int ce_lo,
                            output int oe_viol, output logic [1:0] lanes);
      logic prev_we_n, prev_oe;
      rdy_at = -1; n_rdy = 0; rdata = '0; err = 1'b0;
      we_lo = 0; oe_lo = 0; ce_lo = 0; oe_viol = 0; lanes = 2'b11;
      @(negedge clk);
      m_in.mem_valid = 1'b1; m_in.mem_instr = 1'b0; m_in.mem_addr = addr;
      m_in.mem_wdata = wdata; m_in.mem_wstrb = wstrb;
      prev_we_n = sram_we_n; prev_oe = sram_dq_oe;
      for (int c = 1; c <= maxc; c++) begin
         @(negedge clk);
         m_in.mem_valid = (c == again_at);
         if (m_out.mem_ready) begin
            n_rdy++;
            if (rdy_at < 0) begin rdy_at = c; rdata = m_out.mem_rdata; err = m_out.mem_error; end
         end
         if (!sram_we_n) we_lo++;
         if (!sram_oe_n) oe_lo++;
         if (!sram_ce_n) begin ce_lo++; lanes = {sram_lb_n, sram_ub_n}; end
         if (prev_oe && !sram_dq_oe && !prev_we_n) oe_viol++;
         prev_we_n = sram_we_n; prev_oe = sram_dq_oe;
      end
   endtask

   int          r_at, r_n, r_we, r_oe, r_ce, r_viol;
   logic [31:0] r_dat;
   logic        r_err;
   logic [1:0]  r_lanes;

   task automatic test_reset();
      rst_n = 1'b0;
      m_in = '0; x_in = '0;
      repeat (3) @(negedge clk);
      n_vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe} !== 6'b111110) begin
         n_err++; $display("FAIL rst_strobes: got %b want 111110", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe}); end
      n_vec++; if (m_out !== init_mem_out) begin n_err++; $display("FAIL rst_ram_out: got %h want 0", m_out); end
      n_vec++; if (sram_addr !== 19'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if ({m_out.mem_ready, sram_ce_n} !== 2'b01) begin n_err++; $display("FAIL rst_release_idle: got %b want 01", {m_out.mem_ready, sram_ce_n}); end
   endtask

   task automatic test_full_word();
      do_access(32'h10, 32'hA1B2C3D4, 4'hF, 0, 12, r_at, r_n, r_dat, r_err, r_we, r_oe, r_ce, r_viol, r_lanes);
      n_vec++; if (r_at !== 7) begin n_err++; $display("FAIL wr_full_ready_cycle: got %0d want 7", r_at); end
      n_vec++; if (r_we !== 4) begin n_err++; $display("FAIL wr_full_we_low: got %0d want 4", r_we); end
      n_vec++; if (r_ce !== 6) begin n_err++; $display("FAIL wr_full_ce_low: got %0d want 6", r_ce); end
      n_vec++; if (r_dat !== 32'h0 || r_err !== 1'b0) begin n_err++; $display("FAIL wr_full_resp: got %h/%b want 0/0", r_dat, r_err); end
      n_vec++; if (r_viol !== 0) begin n_err++; $display("FAIL wr_full_oe_order: got %0d want 0", r_viol); end
      n_vec++; if (r_lanes !== 2'b00) begin n_err++; $display("FAIL wr_full_lanes: got %b want 00", r_lanes); end
      do_access(32'h10, 32'h0, 4'h0, 0, 12, r_at, r_n, r_dat, r_err, r_we, r_oe, r_ce, r_viol, r_lanes);
      n_vec++; if (r_at !== 7) begin n_err++; $display("FAIL rd_full_ready_cycle: got %0d want 7", r_at); end
      n_vec++; if (r_dat !== 32'hA1B2C3D4) begin n_err++; $display("FAIL rd_full_data: got %h want a1b2c3d4", r_dat); end
      n_vec++; if (r_oe !== 6 || r_we !== 0) begin n_err++; $display("FAIL rd_full_oe_we: got oe %0d we %0d want 6 0", r_oe, r_we); end
   endtask

   task automatic test_byte_write();
      do_access(32'h10, 32'h00EE0000, 4'h4, 0, 12, r_at, r_n, r_dat, r_err, r_we, r_oe, r_ce, r_viol, r_lanes);
      n_vec++; if (r_at !== 5) begin n_err++; $display("FAIL wr_byte_ready_cycle: got %0d want 5", r_at); end
      n_vec++; if (r_ce !== 3 || r_we !== 2) begin n_err++; $display("FAIL wr_byte_one_phase: got ce %0d we %0d want 3 2", r_ce, r_we); end
      n_vec++; if (r_lanes !== 2'b01) begin n_err++; $display("FAIL wr_byte_lanes: got %b want 01", r_lanes); end
      do_access(32'h10, 32'h0, 4'h0, 0, 12, r_at, r_n, r_dat, r_err, r_we, r_oe, r_ce, r_viol, r_lanes);
      n_vec++; if (r_dat !== 32'hA1EEC3D4) begin n_err++; $display("FAIL wr_byte_readback: got %h want a1eec3d4", r_dat); end
   endtask

   task automatic test_range_error();
      do_access(32'h0010_0000, 32'h0, 4'h0, 0, 8, r_at, r_n, r_dat, r_err, r_we, r_oe, r_ce, r_viol, r_lanes);
      n_vec++; if (r_at !== 1 || r_n !== 1) begin n_err++; $display("FAIL rng_ready: got at %0d n %0d want 1 1", r_at, r_n); end
      n_vec++; if (r_err !== 1'b1 || r_dat !== 32'h0) begin n_err++; $display("FAIL rng_resp: got %b/%h want 1/0", r_err, r_dat); end
      n_vec++; if (r_ce !== 0) begin n_err++; $display("FAIL rng_no_strobe: got %0d want 0", r_ce); end
   endtask

   task automatic test_busy_valid();
      do_access(32'h10, 32'h0, 4'h0, 3, 16, r_at, r_n, r_dat, r_err, r_we, r_oe, r_ce, r_viol, r_lanes);
      n_vec++; if (r_at !== 7 || r_n !== 1) begin n_err++; $display("FAIL busy_ready: got at %0d n %0d want 7 1", r_at, r_n); end
      n_vec++; if (r_oe !== 6) begin n_err++; $display("FAIL busy_no_second: got %0d want 6", r_oe); end
      n_vec++; if (r_dat !== 32'hA1EEC3D4) begin n_err++; $display("FAIL busy_data: got %h want a1eec3d4", r_dat); end
   endtask

   task automatic test_reset_abort();
      int rdy_seen = 0;
      @(negedge clk);
      m_in.mem_valid = 1'b1; m_in.mem_addr = 32'h20; m_in.mem_wdata = 32'h11112222; m_in.mem_wstrb = 4'hF;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         m_in.mem_valid = 1'b0;
         if (m_out.mem_ready) rdy_seen++;
      end
      n_vec++; if (sram_ce_n !== 1'b0) begin n_err++; $display("FAIL abort_busy: got ce_n %b want 0", sram_ce_n); end
      rst_n = 1'b0;
      #1;
      n_vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe} !== 6'b111110) begin
         n_err++; $display("FAIL abort_strobes: got %b want 111110", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe}); end
      repeat (3) begin @(negedge clk); if (m_out.mem_ready) rdy_seen++; end
      rst_n = 1'b1;
      repeat (8) begin @(negedge clk); if (m_out.mem_ready) rdy_seen++; end
      n_vec++; if (rdy_seen !== 0) begin n_err++; $display("FAIL abort_no_ready: got %0d want 0", rdy_seen); end
      do_access(32'h10, 32'h0, 4'h0, 0, 12, r_at, r_n, r_dat, r_err, r_we, r_oe, r_ce, r_viol, r_lanes);
      n_vec++; if (r_at !== 7 || r_dat !== 32'hA1EEC3D4) begin n_err++; $display("FAIL abort_recover: got at %0d data %h want 7 a1eec3d4", r_at, r_dat); end
   endtask

   task automatic test_wait_extremes();
      int at1 = -1, at15 = -1, oe1 = 0, oe15 = 0;
      logic [31:0] d1 = '0, d15 = '0;
      @(negedge clk);
      x_in.mem_valid = 1'b1; x_in.mem_addr = 32'h40; x_in.mem_wstrb = 4'h0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         x_in.mem_valid = 1'b0;
         if (!x1_oe_n) oe1++;
         if (!x15_oe_n) oe15++;
         if (x1_out.mem_ready && at1 < 0) begin at1 = c; d1 = x1_out.mem_rdata; end
         if (x15_out.mem_ready && at15 < 0) begin at15 = c; d15 = x15_out.mem_rdata; end
      end
      n_vec++; if (at1 !== 5) begin n_err++; $display("FAIL w1_ready_cycle: got %0d want 5", at1); end
      n_vec++; if (at15 !== 33) begin n_err++; $display("FAIL w15_ready_cycle: got %0d want 33", at15); end
      n_vec++; if (oe1 !== 4 || oe15 !== 32) begin n_err++; $display("FAIL w_oe_low: got %0d/%0d want 4/32", oe1, oe15); end
      n_vec++; if (d1 !== 32'h12345678 || d15 !== 32'h12345678) begin n_err++; $display("FAIL w_rdata: got %h/%h want 12345678", d1, d15); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_word();
      test_byte_write();
      test_range_error();
      test_busy_valid();
      test_reset_abort();
      test_wait_extremes();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
